exc_int_ctrl: RTL and testbench

//   Consumer side of the STATUS register: reads sta masks, arbitrates exceptions
//   (overflow, unimplemented instr, syscall) and the external interrupt at

---
 rtl/exc_int_ctrl.sv | 118 +++++++++++
 tb/tb_exc_int_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/exc_int_ctrl.sv
// Exception/interrupt controller for the multicycle CPU: arbitrates events at
// instruction boundaries, produces STATUS/EPC/CAUSE write-backs and the handler redirect.
module exc_int_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0008,
  parameter int unsigned SHIFT    = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] sta,
  input  logic        Intr,
  input  logic        Ovr,
  input  logic        Unimpl,
  input  logic        Syscall,
  input  logic        Eret,
  input  logic        Inst_done,
  input  logic [31:0] Pc,
  input  logic [31:0] Next_pc,
  output logic [31:0] Sta_next,
  output logic        Wsta,
  output logic [31:0] Cause,
  output logic        Wcause,
  output logic [31:0] Epc,
  output logic        Wepc,
  output logic        Exc,
  output logic [31:0] Vec_pc,
  output logic        Inta,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, VECT = 2'd2, RET = 2'd3} state_t;

  localparam logic [1:0] CODE_INTR = 2'b00;
  localparam logic [1:0] CODE_SYS  = 2'b01;
  localparam logic [1:0] CODE_UNI  = 2'b10;
  localparam logic [1:0] CODE_OVF  = 2'b11;

  state_t      state, state_nx;
  logic        int_pend;
  logic [1:0]  code, code_nx;
  logic [31:0] epc_q, epc_nx;
  logic [31:0] sta_q, sta_nx;

  // Boundary arbitration and next-state; captured values only change on an accepted event.
  always_comb begin
    state_nx = state;
    code_nx  = code;
    epc_nx   = epc_q;
    sta_nx   = sta_q;
    case (state)
      IDLE: begin
        if (Inst_done) begin
          if (Eret) begin
            sta_nx   = sta >> SHIFT;
            state_nx = RET;
          end else if (Ovr && sta[3]) begin
            code_nx  = CODE_OVF;
            epc_nx   = Pc;
            sta_nx   = sta << SHIFT;
            state_nx = SAVE;
          end else if (Unimpl && sta[2]) begin
            code_nx  = CODE_UNI;
            epc_nx   = Pc;
            sta_nx   = sta << SHIFT;
            state_nx = SAVE;
          end else if (Syscall && sta[1]) begin
            code_nx  = CODE_SYS;
            epc_nx   = Next_pc;
            sta_nx   = sta << SHIFT;
            state_nx = SAVE;
          end else if (int_pend && sta[0]) begin
            code_nx  = CODE_INTR;
            epc_nx   = Next_pc;
            sta_nx   = sta << SHIFT;
            state_nx = SAVE;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      SAVE:    state_nx = VECT;
      VECT:    state_nx = IDLE;
      RET:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, pending interrupt and captured write-back values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      int_pend <= 1'b0;
      code     <= 2'b00;
      epc_q    <= 32'h0;
      sta_q    <= 32'h0;
    end else begin
      state    <= state_nx;
      // A still-asserted level request re-pends right after acknowledge.
      int_pend <= Intr | (int_pend & ~Inta);
      code     <= code_nx;
      epc_q    <= epc_nx;
      sta_q    <= sta_nx;
    end
  end

  assign Sta_next = sta_q;
  assign Epc      = epc_q;
  assign Cause    = {28'h0, code, 2'b00};
  assign Vec_pc   = VEC_BASE;
  assign Wsta     = (state == SAVE) || (state == RET);
  assign Wcause   = (state == SAVE);
  assign Wepc     = (state == SAVE);
  assign Exc      = (state == VECT);
  assign Inta     = (state == VECT) && (code == CODE_INTR);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_exc_int_ctrl.sv
// Directed self-checking bench for exc_int_ctrl.
module tb_exc_int_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Intr, Ovr, Unimpl, Syscall, Eret, Inst_done;
  logic [31:0] sta, Pc, Next_pc;
  logic [31:0] Sta_next, Cause, Epc, Vec_pc;
  logic        Wsta, Wcause, Wepc, Exc, Inta, Busy;

  int checks = 0;
  int errors = 0;

  exc_int_ctrl dut (
    .Clk(Clk), .Rst(Rst), .sta(sta), .Intr(Intr), .Ovr(Ovr), .Unimpl(Unimpl),
    .Syscall(Syscall), .Eret(Eret), .Inst_done(Inst_done), .Pc(Pc), .Next_pc(Next_pc),
    .Sta_next(Sta_next), .Wsta(Wsta), .Cause(Cause), .Wcause(Wcause), .Epc(Epc),
    .Wepc(Wepc), .Exc(Exc), .Vec_pc(Vec_pc), .Inta(Inta), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Ovr = 1'b0; Unimpl = 1'b0; Syscall = 1'b0; Eret = 1'b0; Inst_done = 1'b0;
  endtask

  // Compact view of the one-cycle strobes: {Wsta,Wcause,Wepc,Exc,Inta,Busy}
  function automatic logic [31:0] strb();
    return {26'h0, Wsta, Wcause, Wepc, Exc, Inta, Busy};
  endfunction

  initial begin
    Rst = 1'b1; Intr = 1'b1; sta = 32'h0; Pc = 32'h0; Next_pc = 32'h0;
    clr();
    // 1: reset, Intr held high throughout
    cyc(); cyc();
    chk("rst_strobes", strb(), 32'h0);
    chk("rst_sta_next", Sta_next, 32'h0);
    chk("rst_cause", Cause, 32'h0);
    chk("rst_epc", Epc, 32'h0);
    chk("rst_int_pend", {31'h0, dut.int_pend}, 32'h0);
    chk("vec_pc", Vec_pc, 32'h0000_0008);
    Rst = 1'b0; Intr = 1'b0;
    cyc();

    // 2: overflow entry; boundary inputs kept high in SAVE must be ignored
    sta = 32'hF; Ovr = 1'b1; Inst_done = 1'b1; Pc = 32'h40; Next_pc = 32'h44;
    cyc();
    chk("ovf_save_strobes", strb(), 32'h39);
    chk("ovf_epc", Epc, 32'h40);
    chk("ovf_cause", Cause, 32'hC);
    chk("ovf_sta_next", Sta_next, 32'hF0);
    Pc = 32'h99; Syscall = 1'b1;
    cyc();
    clr();
    chk("ovf_vect_strobes", strb(), 32'h05);
    chk("ovf_epc_hold", Epc, 32'h40);
    chk("ovf_cause_hold", Cause, 32'hC);
    cyc();
    chk("ovf_idle", strb(), 32'h0);

    // 3: one-cycle interrupt pulse, taken at a later boundary
    Intr = 1'b1;
    cyc();
    Intr = 1'b0;
    chk("intr_pend_set", {31'h0, dut.int_pend}, 32'h1);
    cyc();
    chk("intr_no_boundary", strb(), 32'h0);
    Inst_done = 1'b1; Pc = 32'h44; Next_pc = 32'h48;
    cyc();
    clr();
    chk("intr_save_strobes", strb(), 32'h39);
    chk("intr_epc", Epc, 32'h48);
    chk("intr_cause", Cause, 32'h0);
    cyc();
    chk("intr_vect_strobes", strb(), 32'h07);
    cyc();
    chk("intr_pend_clr", {31'h0, dut.int_pend}, 32'h0);
    chk("intr_idle", strb(), 32'h0);

    // 4: masked interrupt stays pending, taken once enabled
    sta = 32'h0E; Intr = 1'b1; Inst_done = 1'b1;
    cyc();
    Intr = 1'b0; clr();
    chk("mask_no_action", strb(), 32'h0);
    cyc();
    chk("mask_pend_kept", {31'h0, dut.int_pend}, 32'h1);
    sta = 32'h0F; Inst_done = 1'b1; Next_pc = 32'h100;
    cyc();
    clr();
    chk("unmask_save", strb(), 32'h39);
    chk("unmask_epc", Epc, 32'h100);
    cyc();
    chk("unmask_vect", strb(), 32'h07);
    cyc();

    // 5: Eret outranks overflow
    sta = 32'hF0; Eret = 1'b1; Ovr = 1'b1; Inst_done = 1'b1;
    cyc();
    clr();
    chk("eret_strobes", strb(), 32'h21);
    chk("eret_sta_next", Sta_next, 32'h0F);
    chk("eret_epc_hold", Epc, 32'h100);
    cyc();
    chk("eret_idle", strb(), 32'h0);

    // 6: reset in SAVE drops the redirect; then unimpl beats syscall
    sta = 32'hF; Ovr = 1'b1; Inst_done = 1'b1; Pc = 32'h80;
    cyc();
    clr();
    chk("rst6_save", strb(), 32'h39);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    chk("rst6_no_exc", strb(), 32'h0);
    chk("rst6_epc", Epc, 32'h0);
    sta = 32'h6; Syscall = 1'b1; Unimpl = 1'b1; Inst_done = 1'b1;
    Pc = 32'h90; Next_pc = 32'h94;
    cyc();
    clr();
    chk("prio_save", strb(), 32'h39);
    chk("prio_cause", Cause, 32'h8);
    chk("prio_epc", Epc, 32'h90);
    chk("prio_sta_next", Sta_next, 32'h60);
    cyc();
    chk("prio_vect", strb(), 32'h05);
    cyc();
    chk("prio_idle", strb(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
